// File: rtl/des_key_pkg.sv
// Shared constants for the sequential DES key schedule: permutation tables,
// per-round rotation amounts and the scheduler state encoding.
package des_key_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int CD_W       = 28;
  localparam int SUBKEY_W   = 48;

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_e;

  // Source positions use DES numbering: position 1 is the most significant bit.
  localparam int PC1 [2*CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [NUM_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Every DES rotation is by one or two places; idx is the 0-based round.
  function automatic logic shift_is_two(input logic [3:0] idx);
    return SHIFTS[idx] == 2;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: selects the 48 subkey bits from the 56-bit C/D pair.
// Pure wiring, no logic.
module des_pc2
  import des_key_pkg::*;
(
  input  logic [2*CD_W:1]   cd_i,
  output logic [SUBKEY_W:1] subkey_o
);

  for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
    assign subkey_o[SUBKEY_W - g] = cd_i[2*CD_W + 1 - PC2[g]];
  end

  // DES positions 9, 18, 22, 25, 35, 38, 43 and 54 never reach a subkey.
  logic unused_dropped;
  assign unused_dropped = ^{cd_i[48], cd_i[39], cd_i[35], cd_i[32],
                            cd_i[22], cd_i[19], cd_i[14], cd_i[3]};

endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: one C/D register pair, one subkey per
// handshake, encrypt order K1..K16 or decrypt order K16..K1.
module des_key_scheduler
  import des_key_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [64:1]         key,
  output logic [SUBKEY_W:1]   subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [5:1]          round_num,
  output logic                subkey_last,
  output logic                busy
);

  state_e             state_q, state_d;
  logic [5:1]         round_q, round_d;
  logic [2*CD_W:1]    cd_q, cd_d;
  logic               dec_q, dec_d;
  logic [2*CD_W:1]    pc1_key;

  for (genvar g = 0; g < 2*CD_W; g++) begin : g_pc1
    assign pc1_key[2*CD_W - g] = key[65 - PC1[g]];
  end

  // Parity bits (DES positions 8, 16, ..., 64) are discarded unchecked.
  logic unused_parity;
  assign unused_parity = ^{key[57], key[49], key[41], key[33],
                           key[25], key[17], key[9],  key[1]};

  function automatic logic [CD_W:1] rot_half(input logic [CD_W:1] v,
                                             input logic left, input logic two);
    if (left) return two ? {v[CD_W-2:1], v[CD_W:CD_W-1]} : {v[CD_W-1:1], v[CD_W]};
    else      return two ? {v[2:1], v[CD_W:3]}           : {v[1], v[CD_W:2]};
  endfunction

  function automatic logic [2*CD_W:1] rot_cd(input logic [2*CD_W:1] cd,
                                             input logic left, input logic two);
    return {rot_half(cd[2*CD_W:CD_W+1], left, two), rot_half(cd[CD_W:1], left, two)};
  endfunction

  always_comb begin
    // NOTE: every next-state signal is defaulted to its register first so no
    // path through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    round_d = round_q;
    cd_d    = cd_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROUND;
          round_d = 5'd1;
          dec_d   = decrypt;
          // C16/D16 equal C0/D0, so decrypt starts from the unrotated PC-1.
          cd_d    = decrypt ? pc1_key : rot_cd(pc1_key, 1'b1, shift_is_two(4'd0));
        end
      end
      ROUND: begin
        if (subkey_ready) begin
          if (round_q == 5'(NUM_ROUNDS)) begin
            state_d = IDLE;
            round_d = 5'd0;
          end else begin
            round_d = round_q + 5'd1;
            cd_d    = dec_q ? rot_cd(cd_q, 1'b0, shift_is_two(4'(5'd16 - round_q)))
                            : rot_cd(cd_q, 1'b1, shift_is_two(round_q[4:1]));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      round_q <= 5'd0;
      cd_q    <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cd_q    <= cd_d;
      dec_q   <= dec_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_i     (cd_q),
    .subkey_o (subkey)
  );

  // Five bits so that delivery 16 is representable alongside idle 0.
  assign round_num    = round_q;
  assign subkey_valid = (state_q == ROUND);
  assign busy         = (state_q == ROUND);
  assign subkey_last  = subkey_valid & (round_q == 5'(NUM_ROUNDS));

endmodule
